// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and width limit for the bit-serial adder
package serial_adder_pkg;
  localparam int WIDTH_MAX = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result valid-ready handshake bundle for serial_adder_ctrl
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// full_adder_usingdecoder: combinational full adder built from a 3:8 one-hot decode of {a,b,c}
module full_adder_usingdecoder (
  input  logic [2:0] in,
  output logic       sum,
  output logic       carry
);
  logic [7:0] dec;
  assign dec   = 8'b1 << in;
  assign sum   = dec[1] | dec[2] | dec[4] | dec[7];
  assign carry = dec[3] | dec[5] | dec[6] | dec[7];
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_OVF_EN adds signed overflow
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             s, c, accept, last;
  full_adder_usingdecoder u_fa (.in({a_sh_q[0], b_sh_q[0], carry_q}), .sum(s), .carry(c));
  assign accept = state_q == IDLE && bus.in_valid;
  assign last   = state_q == RUN && cnt_q == LAST;
  // next state: accept in IDLE, leave RUN after the last bit, release DONE on out_ready
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.in_valid ? RUN : IDLE;
      RUN:     state_d = (cnt_q == LAST) ? DONE : RUN;
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // datapath: load operands on accept, shift one bit per RUN edge, latch result on the last bit
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
      carry_d  = c;
      cnt_d    = cnt_q + 1'b1;
      sum_d    = last ? sum_sh_d : sum_q;
      cout_d   = last ? c : cout_q;
    end
  end
  // state and datapath registers, reset wins over everything
  always_ff @(posedge clk) begin
    state_q  <= rst ? IDLE : state_d;
    a_sh_q   <= rst ? '0 : a_sh_d;
    b_sh_q   <= rst ? '0 : b_sh_d;
    sum_sh_q <= rst ? '0 : sum_sh_d;
    carry_q  <= rst ? 1'b0 : carry_d;
    cnt_q    <= rst ? '0 : cnt_d;
    sum_q    <= rst ? '0 : sum_d;
    cout_q   <= rst ? 1'b0 : cout_d;
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic cim_q, cim_d;
  // carry into the MSB is the carry register value during the last RUN cycle
  always_comb cim_d = last ? carry_q : cim_q;
  // carry-into-MSB register
  always_ff @(posedge clk) cim_q <= rst ? 1'b0 : cim_d;
  assign bus.ovf = cim_q ^ cout_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule
